p4_router_queue_occupancy: RTL and testbench

// Tracks complete-packet occupancy of every egress queue in the P4 router packet buffer.

---
 rtl/p4_router_pkg.sv | 17 +
 rtl/p4_router_queue_counter.sv | 73 +++++++
 rtl/p4_router_queue_occupancy.sv | 107 ++++++++++
 tb/tb_p4_router_queue_occupancy.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/p4_router_pkg.sv
// Shared constants, types and helpers for the P4 router packet-buffer blocks.
package p4_router_pkg;

    localparam int NUM_QUEUES_PER_EGR_PORT    = 8;
    localparam int DEFAULT_NUM_EGR_PORTS      = 4;
    localparam int DEFAULT_MAX_PKTS_PER_QUEUE = 512;

    // Queue-id width; never narrower than one bit so a single-queue build still has a port.
    function automatic int queue_id_w(input int num_queues);
        return (num_queues > 1) ? $clog2(num_queues) : 1;
    endfunction

    localparam int QUEUE_ID_W = queue_id_w(DEFAULT_NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT);

    typedef logic [QUEUE_ID_W-1:0] queue_id_t;

endpackage

// File: rtl/p4_router_queue_counter.sv
// Saturating up/down packet counter for one egress queue, with registered empty/full flags.
module p4_router_queue_counter #(
    parameter int MAX_CNT     = 512,
    parameter int FULL_THRESH = 480,
    parameter int CNT_W       = $clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             sresetn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FULL_THRESH);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] next_cnt_s;
    logic             empty_r;
    logic             full_r;
    logic             ovf_s;
    logic             udf_s;

    // Next count: a simultaneous inc and dec cancel, so they never raise an error.
    always_comb begin
        next_cnt_s = cnt_r;
        ovf_s      = 1'b0;
        udf_s      = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (cnt_r == MAX_C) begin
                    ovf_s = 1'b1;
                end else begin
                    next_cnt_s = cnt_r + CNT_W'(1);
                end
            end
            2'b01: begin
                if (cnt_r == CNT_W'(0)) begin
                    udf_s = 1'b1;
                end else begin
                    next_cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                next_cnt_s = cnt_r;
            end
        endcase
    end

    // Count register; flags are derived from the next count so they land with it.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            cnt_r   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            cnt_r   <= next_cnt_s;
            empty_r <= (next_cnt_s == CNT_W'(0));
            full_r  <= (next_cnt_s >= FULL_C);
        end
    end

    assign cnt   = cnt_r;
    assign empty = empty_r;
    assign full  = full_r;
    assign ovf   = ovf_s;
    assign udf   = udf_s;

endmodule

// File: rtl/p4_router_queue_occupancy.sv
// Complete-packet occupancy per egress queue: empty/full vectors, sticky errors, status read.
module p4_router_queue_occupancy
    import p4_router_pkg::*;
#(
    parameter int NUM_EGR_PORTS      = DEFAULT_NUM_EGR_PORTS,
    parameter int NUM_QUEUES         = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
    parameter int MAX_PKTS_PER_QUEUE = DEFAULT_MAX_PKTS_PER_QUEUE,
    parameter int FULL_THRESH        = 480,
    localparam int QID_W             = queue_id_w(NUM_QUEUES),
    localparam int PKT_CNT_W         = $clog2(MAX_PKTS_PER_QUEUE + 1)
) (
    input  logic                  clk,
    input  logic                  sresetn,
    input  logic                  enq_valid,
    input  logic                  enq_last,
    input  logic [QID_W-1:0]      enq_qid,
    input  logic                  deq_valid,
    input  logic                  deq_last,
    input  logic [QID_W-1:0]      deq_qid,
    output logic [NUM_QUEUES-1:0] queue_empty,
    output logic [NUM_QUEUES-1:0] queue_full,
    input  logic [QID_W-1:0]      stat_qid,
    output logic [PKT_CNT_W-1:0]  stat_count,
    input  logic                  err_clear,
    output logic [NUM_QUEUES-1:0] err_overflow,
    output logic [NUM_QUEUES-1:0] err_underflow
);

    if (NUM_EGR_PORTS <= 0) begin : g_chk_ports
        $error("NUM_EGR_PORTS must be greater than 0");
    end
    if (FULL_THRESH > MAX_PKTS_PER_QUEUE) begin : g_chk_thresh
        $error("FULL_THRESH must not exceed MAX_PKTS_PER_QUEUE");
    end

    logic                  enq_pkt_s;
    logic                  deq_pkt_s;
    logic [NUM_QUEUES-1:0] inc_s;
    logic [NUM_QUEUES-1:0] dec_s;
    logic [NUM_QUEUES-1:0] ovf_s;
    logic [NUM_QUEUES-1:0] udf_s;
    logic [PKT_CNT_W-1:0]  cnt_s [NUM_QUEUES];
    logic [PKT_CNT_W-1:0]  stat_mux_s;
    logic [PKT_CNT_W-1:0]  stat_count_r;
    logic [NUM_QUEUES-1:0] err_ovf_r;
    logic [NUM_QUEUES-1:0] err_udf_r;

    assign enq_pkt_s = enq_valid && enq_last;
    assign deq_pkt_s = deq_valid && deq_last;

    // Out-of-range qids match no decoder slot, so they are silently dropped.
    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        assign inc_s[q] = enq_pkt_s && (enq_qid == QID_W'(q));
        assign dec_s[q] = deq_pkt_s && (deq_qid == QID_W'(q));

        p4_router_queue_counter #(
            .MAX_CNT     (MAX_PKTS_PER_QUEUE),
            .FULL_THRESH (FULL_THRESH),
            .CNT_W       (PKT_CNT_W)
        ) u_counter (
            .clk     (clk),
            .sresetn (sresetn),
            .inc     (inc_s[q]),
            .dec     (dec_s[q]),
            .cnt     (cnt_s[q]),
            .empty   (queue_empty[q]),
            .full    (queue_full[q]),
            .ovf     (ovf_s[q]),
            .udf     (udf_s[q])
        );
    end

    // Status read mux; an unmapped address reads zero.
    always_comb begin
        stat_mux_s = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (stat_qid == QID_W'(q)) begin
                stat_mux_s = cnt_s[q];
            end else begin
                stat_mux_s = stat_mux_s;
            end
        end
    end

    // Sticky error flags and status register; a fresh error beats err_clear.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            err_ovf_r    <= '0;
            err_udf_r    <= '0;
            stat_count_r <= '0;
        end else begin
            stat_count_r <= stat_mux_s;
            if (err_clear) begin
                err_ovf_r <= ovf_s;
                err_udf_r <= udf_s;
            end else begin
                err_ovf_r <= err_ovf_r | ovf_s;
                err_udf_r <= err_udf_r | udf_s;
            end
        end
    end

    assign stat_count    = stat_count_r;
    assign err_overflow  = err_ovf_r;
    assign err_underflow = err_udf_r;

endmodule

// File: tb/tb_p4_router_queue_occupancy.sv
// Scoreboard bench: stimulus queues timed expectations, a negedge monitor compares them.
module tb_p4_router_queue_occupancy;

    localparam int NQ    = 24;
    localparam int QID_W = 5;
    localparam int CNT_W = 10;
    localparam logic [31:0] ALL_Q = 32'h00FF_FFFF;

    localparam int K_EMPTY_BIT = 0;
    localparam int K_EMPTY     = 1;
    localparam int K_FULL_BIT  = 2;
    localparam int K_FULL      = 3;
    localparam int K_OVF       = 4;
    localparam int K_UDF       = 5;
    localparam int K_STAT      = 6;

    typedef struct {
        int          due;
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic             clk;
    logic             sresetn;
    logic             enq_valid, enq_last;
    logic [QID_W-1:0] enq_qid;
    logic             deq_valid, deq_last;
    logic [QID_W-1:0] deq_qid;
    logic [NQ-1:0]    queue_empty, queue_full, err_overflow, err_underflow;
    logic [QID_W-1:0] stat_qid;
    logic [CNT_W-1:0] stat_count;
    logic             err_clear;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    p4_router_queue_occupancy #(
        .NUM_EGR_PORTS (3),
        .FULL_THRESH   (480)
    ) dut (
        .clk           (clk),
        .sresetn       (sresetn),
        .enq_valid     (enq_valid),
        .enq_last      (enq_last),
        .enq_qid       (enq_qid),
        .deq_valid     (deq_valid),
        .deq_last      (deq_last),
        .deq_qid       (deq_qid),
        .queue_empty   (queue_empty),
        .queue_full    (queue_full),
        .stat_qid      (stat_qid),
        .stat_count    (stat_count),
        .err_clear     (err_clear),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind, input int idx);
        case (kind)
            K_EMPTY_BIT: return {31'd0, queue_empty[idx]};
            K_EMPTY:     return {8'd0, queue_empty};
            K_FULL_BIT:  return {31'd0, queue_full[idx]};
            K_FULL:      return {8'd0, queue_full};
            K_OVF:       return {8'd0, err_overflow};
            K_UDF:       return {8'd0, err_underflow};
            K_STAT:      return {22'd0, stat_count};
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [31:0] act;
                act = actual(sb[i].kind, sb[i].idx);
                n_vec = n_vec + 1;
                if (act !== sb[i].exp) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s (cycle %0d): got %0h expected %0h",
                             sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int kind, input int idx, input logic [31:0] exp,
                             input int lat, input string name);
        exp_t e;
        e.due  = cyc + lat;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic ev, input logic el, input int eq,
                        input logic dv, input logic dl, input int dq, input logic clr);
        enq_valid = ev;
        enq_last  = el;
        enq_qid   = QID_W'(eq);
        deq_valid = dv;
        deq_last  = dl;
        deq_qid   = QID_W'(dq);
        err_clear = clr;
        tick();
        enq_valid = 1'b0;
        enq_last  = 1'b0;
        deq_valid = 1'b0;
        deq_last  = 1'b0;
        err_clear = 1'b0;
    endtask

    initial begin
        int wait_cyc;
        sresetn   = 1'b0;
        enq_valid = 1'b0;
        enq_last  = 1'b0;
        enq_qid   = '0;
        deq_valid = 1'b0;
        deq_last  = 1'b0;
        deq_qid   = '0;
        err_clear = 1'b0;
        stat_qid  = '0;
        tick();
        tick();
        sresetn = 1'b1;

        n_vec = n_vec + 1;
        if (queue_empty !== {NQ{1'b1}}) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_rst_empty: got %0h", queue_empty);
        end
        n_vec = n_vec + 1;
        if (queue_full !== {NQ{1'b0}}) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_rst_full: got %0h", queue_full);
        end
        n_vec = n_vec + 1;
        if ((err_overflow | err_underflow) !== {NQ{1'b0}}) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_rst_err: got %0h %0h", err_overflow, err_underflow);
        end
        n_vec = n_vec + 1;
        if (stat_count !== {CNT_W{1'b0}}) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_rst_stat: got %0h", stat_count);
        end

        expect_at(K_EMPTY, 0, ALL_Q, 0, "rst_empty");
        expect_at(K_FULL,  0, 32'd0, 0, "rst_full");
        expect_at(K_OVF,   0, 32'd0, 0, "rst_ovf");
        expect_at(K_UDF,   0, 32'd0, 0, "rst_udf");
        expect_at(K_STAT,  0, 32'd0, 0, "rst_stat");
        tick();

        // Three 4-beat packets to qid 5
        stat_qid = 5'd5;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                beat(1'b1, (b == 3), 5, 1'b0, 1'b0, 0, 1'b0);
                if (b < 3 && p == 0) expect_at(K_EMPTY_BIT, 5, 32'd1, 0, "nonlast_empty5");
                if (b == 2) expect_at(K_STAT, 0, p, 1, "nonlast_hold");
                if (b == 3) begin
                    expect_at(K_EMPTY_BIT, 5, 32'd0, 0, "last_empty5");
                    expect_at(K_STAT, 0, p + 1, 1, "enq_count5");
                end
            end
        end
        tick();
        expect_at(K_EMPTY, 0, ALL_Q & ~32'h20, 0, "empty_vec_q5");

        // Simultaneous enq/deq at count 1, then a lone dequeue
        beat(1'b0, 1'b0, 0, 1'b1, 1'b1, 5, 1'b0);
        beat(1'b0, 1'b0, 0, 1'b1, 1'b1, 5, 1'b0);
        expect_at(K_STAT, 0, 32'd1, 1, "deq_to_1");
        tick();
        beat(1'b1, 1'b1, 5, 1'b1, 1'b1, 5, 1'b0);
        expect_at(K_EMPTY_BIT, 5, 32'd0, 0, "both_empty5");
        expect_at(K_STAT, 0, 32'd1, 1, "both_count5");
        expect_at(K_UDF, 0, 32'd0, 0, "both_no_udf");
        beat(1'b0, 1'b0, 0, 1'b1, 1'b1, 5, 1'b0);
        expect_at(K_EMPTY_BIT, 5, 32'd1, 0, "drain_empty5");
        expect_at(K_STAT, 0, 32'd0, 1, "drain_count5");
        expect_at(K_UDF, 0, 32'd0, 0, "drain_no_udf");
        tick();

        // Underflow on qid 2 and err_clear interaction
        beat(1'b0, 1'b0, 0, 1'b1, 1'b1, 2, 1'b0);
        expect_at(K_UDF, 0, 32'h4, 0, "udf_q2");
        expect_at(K_EMPTY_BIT, 2, 32'd1, 0, "udf_empty2");
        beat(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        expect_at(K_UDF, 0, 32'd0, 0, "udf_cleared");
        beat(1'b0, 1'b0, 0, 1'b1, 1'b1, 2, 1'b1);
        expect_at(K_UDF, 0, 32'h4, 0, "udf_wins_clear");
        tick();
        expect_at(K_UDF, 0, 32'h4, 0, "udf_sticky");
        beat(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        expect_at(K_UDF, 0, 32'd0, 0, "udf_cleared2");

        // Out-of-range qids are ignored
        beat(1'b1, 1'b1, 30, 1'b1, 1'b1, 27, 1'b0);
        expect_at(K_OVF, 0, 32'd0, 0, "oor_no_ovf");
        expect_at(K_UDF, 0, 32'd0, 0, "oor_no_udf");
        expect_at(K_EMPTY, 0, ALL_Q, 0, "oor_empty");

        // Fill qid 0 through threshold to saturation
        stat_qid = 5'd0;
        for (int k = 1; k <= 512; k++) begin
            beat(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
            if (k == 479) expect_at(K_FULL_BIT, 0, 32'd0, 0, "full_479");
            if (k == 480) begin
                expect_at(K_FULL_BIT, 0, 32'd1, 0, "full_480");
                expect_at(K_STAT, 0, 32'd480, 1, "count_480");
            end
            if (k == 512) begin
                expect_at(K_STAT, 0, 32'd512, 1, "count_512");
                expect_at(K_OVF, 0, 32'd0, 0, "no_ovf_512");
            end
        end
        beat(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
        expect_at(K_OVF, 0, 32'h1, 0, "ovf_q0");
        expect_at(K_STAT, 0, 32'd512, 1, "sat_hold");
        expect_at(K_FULL, 0, 32'h1, 0, "full_vec");
        beat(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        expect_at(K_OVF, 0, 32'd0, 0, "ovf_cleared");
        beat(1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0);
        expect_at(K_OVF, 0, 32'd0, 0, "both_at_max_ovf");
        expect_at(K_STAT, 0, 32'd512, 1, "both_at_max_cnt");
        beat(1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0);
        expect_at(K_STAT, 0, 32'd511, 1, "count_511");
        expect_at(K_FULL_BIT, 0, 32'd1, 0, "full_511");

        // Reset mid-traffic with qids 0..7 occupied
        for (int q = 1; q < 8; q++) beat(1'b1, 1'b1, q, 1'b0, 1'b0, 0, 1'b0);
        expect_at(K_EMPTY, 0, ALL_Q & ~32'hFF, 0, "busy_empty");
        sresetn = 1'b0;
        beat(1'b1, 1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
        sresetn = 1'b1;
        expect_at(K_EMPTY, 0, ALL_Q, 0, "mid_rst_empty");
        expect_at(K_FULL,  0, 32'd0, 0, "mid_rst_full");
        expect_at(K_STAT,  0, 32'd0, 0, "mid_rst_stat");
        expect_at(K_STAT,  0, 32'd0, 1, "mid_rst_cnt0");
        expect_at(K_EMPTY_BIT, 3, 32'd1, 1, "mid_rst_q3");
        tick();
        tick();

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        foreach (sb[i]) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: expectation never checked (due %0d, now %0d)",
                     sb[i].name, sb[i].due, cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
